// File: rtl/uart_frame_arbiter_pkg.sv
// Shared constants for the UART frame arbiter and the packet producers feeding it:
// start-of-frame byte, default sizing and the state encodings of the arbiter and byte issuer.
package uart_frame_arbiter_pkg;

    localparam int         NUM_REQ_DEFAULT = 2;
    localparam int         MAX_LEN_DEFAULT = 16;
    localparam logic [7:0] SOF_BYTE        = 8'hA5;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SOF   = 3'd1;
    localparam logic [2:0] ST_ID    = 3'd2;
    localparam logic [2:0] ST_FETCH = 3'd3;
    localparam logic [2:0] ST_PAY   = 3'd4;
    localparam logic [2:0] ST_CHK   = 3'd5;
    localparam logic [2:0] ST_DONE  = 3'd6;

    localparam logic [1:0] IS_IDLE    = 2'd0;
    localparam logic [1:0] IS_WAIT_HI = 2'd1;
    localparam logic [1:0] IS_WAIT_LO = 2'd2;

    function automatic logic is_tx_state(input logic [2:0] st);
        return (st == ST_SOF) || (st == ST_ID) || (st == ST_PAY) || (st == ST_CHK);
    endfunction

endpackage

// File: rtl/uart_frame_arbiter_issue.sv
// Single-byte issue handshake towards the UART byte transmitter: one tx_start pulse,
// then a rising and a falling tx_busy edge before done is reported.
module uart_byte_issue
    import uart_frame_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] data,
    output logic       done,
    output logic       tx_start,
    output logic [7:0] tx_data,
    input  logic       tx_busy
);

    logic [1:0] phase_q, phase_d;
    logic       tx_start_q, tx_start_d;
    logic [7:0] tx_data_q, tx_data_d;
    logic       busy_prev_q, busy_prev_d;

    always_comb begin
        phase_d     = phase_q;
        tx_start_d  = 1'b0;
        tx_data_d   = tx_data_q;
        busy_prev_d = tx_busy;
        done        = 1'b0;
        case (phase_q)
            IS_IDLE: begin
                if (start) begin
                    phase_d    = IS_WAIT_HI;
                    tx_start_d = 1'b1;
                    tx_data_d  = data;
                end
            end
            // A busy level already present in the tx_start cycle does not count as acceptance.
            IS_WAIT_HI: begin
                if (!tx_start_q && tx_busy && !busy_prev_q) begin
                    phase_d = IS_WAIT_LO;
                end
            end
            IS_WAIT_LO: begin
                if (!tx_busy) begin
                    done    = 1'b1;
                    phase_d = IS_IDLE;
                end
            end
            default: phase_d = IS_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q     <= IS_IDLE;
            tx_start_q  <= 1'b0;
            tx_data_q   <= 8'h00;
            busy_prev_q <= 1'b0;
        end else begin
            phase_q     <= phase_d;
            tx_start_q  <= tx_start_d;
            tx_data_q   <= tx_data_d;
            busy_prev_q <= busy_prev_d;
        end
    end

    assign tx_start = tx_start_q;
    assign tx_data  = tx_data_q;

endmodule

// File: rtl/uart_frame_arbiter.sv
// Round-robin, frame-atomic arbiter that serialises requester payloads into
// SOF / ID / payload / XOR-checksum frames for a UART byte transmitter.
module uart_frame_arbiter
    import uart_frame_arbiter_pkg::*;
#(
    parameter int         NUM_REQ = NUM_REQ_DEFAULT,
    parameter int         MAX_LEN = MAX_LEN_DEFAULT,
    parameter logic [7:0] SOF     = SOF_BYTE
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [7:0]           tx_data,
    output logic                 tx_start,
    input  logic                 tx_busy,
    output logic [NUM_REQ-1:0]   grant,
    output logic                 frame_done,
    output logic                 busy
);

    localparam int OW = $clog2(NUM_REQ);
    localparam int CW = $clog2(MAX_LEN + 1);

    logic [2:0]         state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [OW-1:0]      owner_q, owner_d;
    logic [OW-1:0]      ptr_q, ptr_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [7:0]         chk_q, chk_d;
    logic [7:0]         pay_q, pay_d;
    logic               last_q, last_d;
    logic               busy_q, busy_d;
    logic               issued_q, issued_d;

    logic               found;
    logic [OW-1:0]      pick;
    logic [OW:0]        idx;
    logic [7:0]         fetch_byte;
    logic [7:0]         issue_byte;
    logic               issue_start;
    logic               issue_done;

    // Round-robin search starting at the index after the previous winner.
    always_comb begin
        found = 1'b0;
        pick  = ptr_q;
        idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (OW+1)'(ptr_q) + (OW+1)'(k);
            if (idx >= (OW+1)'(NUM_REQ)) begin
                idx = idx - (OW+1)'(NUM_REQ);
            end
            if (!found && req_valid[idx[OW-1:0]]) begin
                found = 1'b1;
                pick  = idx[OW-1:0];
            end
        end
    end

    assign fetch_byte = req_data[8*owner_q +: 8];

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        owner_d     = owner_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        chk_d       = chk_q;
        pay_d       = pay_q;
        last_d      = last_q;
        busy_d      = busy_q;
        issued_d    = issued_q;
        req_ready   = '0;
        frame_done  = 1'b0;
        issue_start = is_tx_state(state_q) && !issued_q;
        if (issue_start) begin
            issued_d = 1'b1;
        end
        if (issue_done) begin
            issued_d = 1'b0;
        end
        case (state_q)
            ST_IDLE: begin
                if (found) begin
                    grant_d       = '0;
                    grant_d[pick] = 1'b1;
                    owner_d       = pick;
                    cnt_d         = '0;
                    chk_d         = {{(8-OW){1'b0}}, pick};
                    busy_d        = 1'b1;
                    state_d       = ST_SOF;
                end
            end
            ST_SOF:   if (issue_done) state_d = ST_ID;
            ST_ID:    if (issue_done) state_d = ST_FETCH;
            ST_FETCH: begin
                if (req_valid[owner_q]) begin
                    req_ready[owner_q] = 1'b1;
                    pay_d              = fetch_byte;
                    last_d             = req_last[owner_q];
                    chk_d              = chk_q ^ fetch_byte;
                    if (cnt_q != CW'(MAX_LEN)) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                    state_d = ST_PAY;
                end
            end
            // Reaching MAX_LEN closes the frame even without last; the rest becomes a new frame.
            ST_PAY: begin
                if (issue_done) begin
                    state_d = (last_q || cnt_q == CW'(MAX_LEN)) ? ST_CHK : ST_FETCH;
                end
            end
            ST_CHK:   if (issue_done) state_d = ST_DONE;
            ST_DONE: begin
                frame_done = 1'b1;
                grant_d    = '0;
                busy_d     = 1'b0;
                ptr_d      = (owner_q == OW'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        case (state_q)
            ST_SOF:  issue_byte = SOF;
            ST_ID:   issue_byte = {{(8-OW){1'b0}}, owner_q};
            ST_PAY:  issue_byte = pay_q;
            default: issue_byte = chk_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            grant_q  <= '0;
            owner_q  <= '0;
            ptr_q    <= '0;
            cnt_q    <= '0;
            chk_q    <= 8'h00;
            pay_q    <= 8'h00;
            last_q   <= 1'b0;
            busy_q   <= 1'b0;
            issued_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            owner_q  <= owner_d;
            ptr_q    <= ptr_d;
            cnt_q    <= cnt_d;
            chk_q    <= chk_d;
            pay_q    <= pay_d;
            last_q   <= last_d;
            busy_q   <= busy_d;
            issued_q <= issued_d;
        end
    end

    uart_byte_issue u_issue (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (issue_start),
        .data     (issue_byte),
        .done     (issue_done),
        .tx_start (tx_start),
        .tx_data  (tx_data),
        .tx_busy  (tx_busy)
    );

    assign grant = grant_q;
    assign busy  = busy_q;

endmodule

// File: tb/tb_uart_frame_arbiter.sv
// Scoreboard bench for uart_frame_arbiter: directed frames, a 10-cycle busy transmitter
// model, and a negedge monitor comparing wire bytes and frame owners against queued expectations.
module tb_uart_frame_arbiter;

    logic        clk;
    logic        rst_n;
    logic [1:0]  req_valid;
    logic [15:0] req_data;
    logic [1:0]  req_last;
    logic [1:0]  req_ready;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic        tx_busy;
    logic [1:0]  grant;
    logic        frame_done;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;

    logic [7:0] exp_q[$];
    int         exp_own[$];
    logic [8:0] rq0[$];
    logic [8:0] rq1[$];
    logic       hold0 = 1'b0;

    uart_frame_arbiter dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_last   (req_last),
        .req_ready  (req_ready),
        .tx_data    (tx_data),
        .tx_start   (tx_start),
        .tx_busy    (tx_busy),
        .grant      (grant),
        .frame_done (frame_done),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Transmitter model: busy rises the cycle after tx_start and stays up for 10 cycles.
    initial begin
        tx_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && tx_start === 1'b1) begin
                @(posedge clk);
                #1 tx_busy = 1'b1;
                repeat (10) @(posedge clk);
                #1 tx_busy = 1'b0;
            end
        end
    end

    // Requester driver: present queue heads at negedge, pop once a byte was accepted.
    initial begin
        logic       pend0;
        logic       pend1;
        logic [8:0] tmp;
        pend0 = 1'b0;
        pend1 = 1'b0;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        forever begin
            @(negedge clk);
            if (rst_n !== 1'b1) begin
                pend0 = 1'b0;
                pend1 = 1'b0;
            end
            if (pend0 && rq0.size() > 0) tmp = rq0.pop_front();
            if (pend1 && rq1.size() > 0) tmp = rq1.pop_front();
            if (rq0.size() > 0 && !hold0) begin
                req_valid[0]   = 1'b1;
                req_data[7:0]  = rq0[0][7:0];
                req_last[0]    = rq0[0][8];
            end else begin
                req_valid[0]   = 1'b0;
                req_last[0]    = 1'b0;
            end
            if (rq1.size() > 0) begin
                req_valid[1]   = 1'b1;
                req_data[15:8] = rq1[0][7:0];
                req_last[1]    = rq1[0][8];
            end else begin
                req_valid[1]   = 1'b0;
                req_last[1]    = 1'b0;
            end
            #1;
            pend0 = req_ready[0];
            pend1 = req_ready[1];
        end
    end

    // Monitor: wire bytes, tx_data stability, frame owners and invariants.
    initial begin
        logic       stab_pend;
        logic       busy_seen;
        logic [7:0] stab_byte;
        logic [7:0] e;
        logic [1:0] eg;
        int         o;
        stab_pend = 1'b0;
        busy_seen = 1'b0;
        stab_byte = 8'h00;
        forever begin
            @(negedge clk);
            if (rst_n !== 1'b1) begin
                stab_pend = 1'b0;
            end else begin
                if (stab_pend) begin
                    if (!tx_busy && busy_seen) begin
                        stab_pend = 1'b0;
                    end else begin
                        checks++;
                        if (tx_data !== stab_byte) begin
                            errors++;
                            $display("FAIL tx_data_stable got %02h want %02h", tx_data, stab_byte);
                        end
                        if (tx_busy) busy_seen = 1'b1;
                    end
                end
                if (tx_start === 1'b1) begin
                    checks++;
                    if (tx_busy !== 1'b0) begin
                        errors++;
                        $display("FAIL busy_before_start got %b want 0", tx_busy);
                    end
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_byte got %02h want none", tx_data);
                    end else begin
                        e = exp_q.pop_front();
                        if (tx_data !== e) begin
                            errors++;
                            $display("FAIL wire_byte got %02h want %02h", tx_data, e);
                        end
                    end
                    stab_pend = 1'b1;
                    busy_seen = 1'b0;
                    stab_byte = tx_data;
                end
                if (frame_done === 1'b1) begin
                    done_cnt++;
                    checks++;
                    if (exp_own.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_frame_done grant %b want no frame", grant);
                    end else begin
                        o  = exp_own.pop_front();
                        eg = 2'b00;
                        eg[o] = 1'b1;
                        if (grant !== eg) begin
                            errors++;
                            $display("FAIL frame_owner got %b want %b", grant, eg);
                        end
                    end
                end
                if ((req_ready & ~grant) != 2'b00 || grant == 2'b11) begin
                    checks++;
                    errors++;
                    $display("FAIL ready_grant_invariant ready %b grant %b", req_ready, grant);
                end
            end
        end
    end

    task automatic load(input int r, input logic [7:0] d, input logic l);
        if (r == 0) rq0.push_back({l, d});
        else        rq1.push_back({l, d});
    endtask

    task automatic exp_hdr(input int owner);
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'(owner));
        exp_own.push_back(owner);
    endtask

    task automatic check(input string nm, input logic [15:0] got, input logic [15:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0h want %0h", nm, got, want);
        end
    endtask

    task automatic check_reset_outputs(input string nm);
        check({nm, "_tx_start"},   16'(tx_start),   16'h0);
        check({nm, "_tx_data"},    16'(tx_data),    16'h0);
        check({nm, "_req_ready"},  16'(req_ready),  16'h0);
        check({nm, "_grant"},      16'(grant),      16'h0);
        check({nm, "_frame_done"}, 16'(frame_done), 16'h0);
        check({nm, "_busy"},       16'(busy),       16'h0);
    endtask

    task automatic wait_idle(input int budget, input string nm);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || exp_own.size() != 0 || busy !== 1'b0 ||
                rq0.size() != 0 || rq1.size() != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= budget) begin
            errors++;
            $display("FAIL %s_timeout got %0d cycles want below %0d", nm, n, budget);
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got no finish want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("por");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Single frame from requester 0.
        exp_hdr(0);
        exp_q.push_back(8'h11); exp_q.push_back(8'h22); exp_q.push_back(8'h33);
        exp_q.push_back(8'h00);
        load(0, 8'h11, 1'b0); load(0, 8'h22, 1'b0); load(0, 8'h33, 1'b1);
        wait_idle(1000, "single");

        // Simultaneous requests after reset: requester 0 first, then 1.
        pulse_reset();
        exp_hdr(0);
        exp_q.push_back(8'h01); exp_q.push_back(8'h02); exp_q.push_back(8'h03);
        exp_hdr(1);
        exp_q.push_back(8'hAA); exp_q.push_back(8'hAB);
        load(0, 8'h01, 1'b0); load(0, 8'h02, 1'b1);
        load(1, 8'hAA, 1'b1);
        wait_idle(2000, "both");

        // 20-byte stream from requester 1, truncated at 16 payload bytes.
        exp_hdr(1);
        for (int i = 1; i <= 16; i++) exp_q.push_back(8'(i));
        exp_q.push_back(8'h11);
        exp_hdr(1);
        for (int i = 17; i <= 20; i++) exp_q.push_back(8'(i));
        exp_q.push_back(8'h05);
        for (int i = 1; i <= 20; i++) load(1, 8'(i), i == 20);
        wait_idle(3000, "maxlen");

        // Requester 0 stalls mid-frame while requester 1 waits.
        exp_hdr(0);
        exp_q.push_back(8'h5A); exp_q.push_back(8'h3C); exp_q.push_back(8'h99);
        exp_q.push_back(8'hFF);
        exp_hdr(1);
        exp_q.push_back(8'h77); exp_q.push_back(8'h76);
        load(0, 8'h5A, 1'b0); load(0, 8'h3C, 1'b0); load(0, 8'h99, 1'b1);
        load(1, 8'h77, 1'b1);
        n = 0;
        while (rq0.size() != 2 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("stall_first_byte_taken", 16'(rq0.size()), 16'd2);
        hold0 = 1'b1;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            check("stall_grant", 16'(grant), 16'h1);
            check("stall_ready", 16'(req_ready), 16'h0);
        end
        hold0 = 1'b0;
        wait_idle(2000, "stall");

        // Reset while the payload byte is on the wire.
        exp_hdr(0);
        void'(exp_own.pop_back());
        exp_q.push_back(8'h42);
        load(0, 8'h42, 1'b0); load(0, 8'h43, 1'b1);
        n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("midreset_payload_sent", 16'(exp_q.size()), 16'd0);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("async");
        rq0.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("post_reset_tx_start", 16'(tx_start), 16'h0);
            check("post_reset_grant", 16'(grant), 16'h0);
        end

        check("frame_done_count", 16'(done_cnt), 16'd7);
        check("exp_bytes_left", 16'(exp_q.size()), 16'd0);
        check("exp_frames_left", 16'(exp_own.size()), 16'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
